// File: rtl/mac_job_scheduler_if.sv
// Client-side bundle for mac_job_scheduler: two job requesters sharing one MAC.
// Ports: req_x/len_x job request and term count; a_x/b_x/op_valid_x operand
//   stream; op_ready_x operand accept; gnt_x datapath ownership;
//   res/res_valid/res_owner tagged job result (res holds between jobs).
interface mac_job_scheduler_if #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int LEN_WIDTH = 4
);
   logic                 req_0;
   logic                 req_1;
   logic [LEN_WIDTH-1:0] len_0;
   logic [LEN_WIDTH-1:0] len_1;
   logic [WIDTH-1:0]     a_0;
   logic [WIDTH-1:0]     b_0;
   logic [WIDTH-1:0]     a_1;
   logic [WIDTH-1:0]     b_1;
   logic                 op_valid_0;
   logic                 op_valid_1;
   logic                 op_ready_0;
   logic                 op_ready_1;
   logic                 gnt_0;
   logic                 gnt_1;
   logic [ACC_WIDTH-1:0] res;
   logic                 res_valid;
   logic                 res_owner;

   modport master (
      output req_0, req_1, len_0, len_1,
      output a_0, b_0, a_1, b_1,
      output op_valid_0, op_valid_1,
      input  op_ready_0, op_ready_1,
      input  gnt_0, gnt_1,
      input  res, res_valid, res_owner
   );

   modport slave (
      input  req_0, req_1, len_0, len_1,
      input  a_0, b_0, a_1, b_1,
      input  op_valid_0, op_valid_1,
      output op_ready_0, op_ready_1,
      output gnt_0, gnt_1,
      output res, res_valid, res_owner
   );
endinterface

// File: rtl/mac_job_scheduler.sv
// Round-robin scheduler sharing one registered multiply/accumulate datapath.
// Ports: clk; reset (async, active-low); bus (slave side of the job bundle).
module mac_job_scheduler #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int LEN_WIDTH = 4
) (
   input logic                clk,
   input logic                reset,
   mac_job_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 last_q, last_d;
   logic [LEN_WIDTH-1:0] count_q, count_d;
   logic [ACC_WIDTH-1:0] mult_q, mult_d;
   logic [ACC_WIDTH-1:0] accum_q, accum_d;
   logic [ACC_WIDTH-1:0] res_q, res_d;
   logic                 res_own_q, res_own_d;
   logic                 pipe_v_q, pipe_v_d;

   logic [WIDTH-1:0]     a_sel;
   logic [WIDTH-1:0]     b_sel;
   logic                 valid_sel;
   logic                 accept;
   logic                 winner;
   logic                 any_req;
   logic [LEN_WIDTH-1:0] win_len;
   logic [2*WIDTH-1:0]   prod;
   logic [ACC_WIDTH-1:0] acc_sum;

   // Only the owner's operand stream reaches the multiplier.
   assign a_sel     = owner_q ? bus.a_1 : bus.a_0;
   assign b_sel     = owner_q ? bus.b_1 : bus.b_0;
   assign valid_sel = owner_q ? bus.op_valid_1 : bus.op_valid_0;
   assign accept    = (state_q == FEED) & valid_sel;

   assign prod = {{WIDTH{1'b0}}, a_sel} * {{WIDTH{1'b0}}, b_sel};
   assign acc_sum = accum_q + mult_q;

   // Tie goes to whoever did not win last time.
   assign any_req = bus.req_0 | bus.req_1;
   assign winner  = (bus.req_0 & bus.req_1) ? ~last_q : bus.req_1;
   assign win_len = winner ? bus.len_1 : bus.len_0;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      count_d   = count_q;
      mult_d    = mult_q;
      pipe_v_d  = 1'b0;
      res_d     = res_q;
      res_own_d = res_own_q;
      accum_d   = pipe_v_q ? acc_sum : accum_q;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               owner_d = winner;
               last_d  = winner;
               count_d = win_len;
               accum_d = '0;
               if (win_len == '0) begin
                  state_d   = DONE;
                  res_d     = '0;
                  res_own_d = winner;
               end else begin
                  state_d = FEED;
               end
            end
         end
         FEED: begin
            if (accept) begin
               mult_d   = ACC_WIDTH'(prod);
               pipe_v_d = 1'b1;
               count_d  = count_q - 1'b1;
               if (count_q == LEN_WIDTH'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Last product lands this edge; capture the final sum directly.
            state_d   = DONE;
            res_d     = accum_d;
            res_own_d = owner_q;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         count_q   <= '0;
         mult_q    <= '0;
         accum_q   <= '0;
         res_q     <= '0;
         res_own_q <= 1'b0;
         pipe_v_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         count_q   <= count_d;
         mult_q    <= mult_d;
         accum_q   <= accum_d;
         res_q     <= res_d;
         res_own_q <= res_own_d;
         pipe_v_q  <= pipe_v_d;
      end
   end

   assign bus.op_ready_0 = (state_q == FEED) & ~owner_q;
   assign bus.op_ready_1 = (state_q == FEED) & owner_q;
   assign bus.gnt_0      = (state_q != IDLE) & ~owner_q;
   assign bus.gnt_1      = (state_q != IDLE) & owner_q;
   assign bus.res        = res_q;
   assign bus.res_valid  = (state_q == DONE);
   assign bus.res_owner  = res_own_q;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Self-checking bench for mac_job_scheduler: directed vector table,
// hand-written tie/reset sequences and a randomized two-client model.
`timescale 1ns/1ps
module tb_mac_job_scheduler;
   localparam int W  = 8;
   localparam int AW = 16;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mac_job_scheduler_if #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) bus();

   mac_job_scheduler #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            who;
      logic [3:0]      len;
      logic [3:0][7:0] a;
      logic [3:0][7:0] b;
      logic [15:0]     vmask;
      logic [15:0]     exp_res;
      logic [4:0]      exp_rdy;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic rdy(input logic s);
      return s ? bus.op_ready_1 : bus.op_ready_0;
   endfunction

   function automatic logic gnt(input logic s);
      return s ? bus.gnt_1 : bus.gnt_0;
   endfunction

   task automatic drive_side(input logic s, input logic r, input logic [3:0] l,
                             input logic v, input logic [7:0] a,
                             input logic [7:0] b);
      if (s) begin
         bus.req_1 = r; bus.len_1 = l; bus.op_valid_1 = v;
         bus.a_1 = a; bus.b_1 = b;
      end else begin
         bus.req_0 = r; bus.len_0 = l; bus.op_valid_0 = v;
         bus.a_0 = a; bus.b_0 = b;
      end
   endtask

   task automatic idle_inputs();
      drive_side(1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 8'd0);
      drive_side(1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 8'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int   cyc, acc, k, rdyn, lat, guard;
      logic vb, bad;
      bad = 1'b0; rdyn = 0; acc = 0; k = 0; guard = 0;
      @(negedge clk);
      drive_side(v.who, 1'b1, v.len, 1'b0, 8'd0, 8'd0);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!gnt(v.who) && cyc < 20);
      check($sformatf("v%0d grant_edges", n), cyc, 1);
      drive_side(v.who, 1'b0, v.len, 1'b0, 8'd0, 8'd0);
      while (acc < int'(v.len) && guard < 64) begin
         if (rdy(!v.who) || gnt(!v.who)) bad = 1'b1;
         vb = 1'b0;
         if (rdy(v.who)) begin
            rdyn++;
            vb = (k < 16) ? v.vmask[k] : 1'b1;
            k++;
         end
         drive_side(v.who, 1'b0, v.len, vb, v.a[acc], v.b[acc]);
         if (vb) acc++;
         @(negedge clk);
         guard++;
      end
      drive_side(v.who, 1'b0, v.len, 1'b0, 8'd0, 8'd0);
      check($sformatf("v%0d accepted", n), acc, v.len);
      lat = 0;
      while (!bus.res_valid && lat < 10) begin
         if (rdy(v.who)) rdyn++;
         if (rdy(!v.who) || gnt(!v.who)) bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      check($sformatf("v%0d latency", n), lat, (v.len == 0) ? 0 : 1);
      check($sformatf("v%0d res_valid", n), bus.res_valid, 1);
      check($sformatf("v%0d res", n), bus.res, v.exp_res);
      check($sformatf("v%0d res_owner", n), bus.res_owner, v.who);
      check($sformatf("v%0d gnt_done", n), gnt(v.who), 1);
      check($sformatf("v%0d ready_cycles", n), rdyn, v.exp_rdy);
      check($sformatf("v%0d other_side_idle", n), bad, 0);
      @(negedge clk);
      check($sformatf("v%0d pulse_end", n), bus.res_valid, 0);
      check($sformatf("v%0d gnt_release", n), gnt(v.who), 0);
      check($sformatf("v%0d res_hold", n), bus.res, v.exp_res);
   endtask

   // Randomized-run state: one pending job per client.
   logic [7:0]  ja[2][16];
   logic [7:0]  jb[2][16];
   int          jlen[2];
   bit          pend[2];
   int          idx[2];
   bit          busy, done_seen, last_m, exp_own, stray, vbr;
   logic [15:0] exp_res;
   int          busy_cyc, jobs;

   task automatic new_job(input int s);
      jlen[s] = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
         ja[s][i] = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom);
         jb[s][i] = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom);
      end
      pend[s] = 1'b1;
      idx[s]  = 0;
   endtask

   function automatic logic [15:0] job_sum(input int s);
      int unsigned sum = 0;
      for (int i = 0; i < jlen[s]; i++) sum += ja[s][i] * jb[s][i];
      return sum[15:0];
   endfunction

   initial begin
      int   got, cyc;
      logic bad;
      vec_t v;

      reset = 1'b0;
      idle_inputs();

      vecs[0] = '{who: 1'b0, len: 4'd3,
                  a: {8'd0, 8'd10, 8'd4, 8'd2}, b: {8'd0, 8'd10, 8'd5, 8'd3},
                  vmask: 16'hFFFF, exp_res: 16'd126, exp_rdy: 5'd3};
      vecs[1] = '{who: 1'b0, len: 4'd2,
                  a: {8'd0, 8'd0, 8'd255, 8'd255}, b: {8'd0, 8'd0, 8'd255, 8'd255},
                  vmask: 16'hFFFF, exp_res: 16'd64514, exp_rdy: 5'd2};
      vecs[2] = '{who: 1'b1, len: 4'd4,
                  a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd4, 8'd3, 8'd2, 8'd1},
                  vmask: 16'h0059, exp_res: 16'd30, exp_rdy: 5'd7};
      vecs[3] = '{who: 1'b1, len: 4'd0,
                  a: '0, b: '0,
                  vmask: 16'hFFFF, exp_res: 16'd0, exp_rdy: 5'd0};
      vecs[4] = '{who: 1'b0, len: 4'd4,
                  a: {8'd17, 8'd200, 8'd0, 8'd3}, b: {8'd17, 8'd100, 8'd9, 8'd7},
                  vmask: 16'hFFFD, exp_res: 16'd20310, exp_rdy: 5'd5};

      #1;
      check("reset gnt_0", bus.gnt_0, 0);
      check("reset res", bus.res, 0);
      check("reset res_valid", bus.res_valid, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Tie: both clients hold req from reset, served alternately from 0.
      do_reset();
      drive_side(1'b0, 1'b1, 4'd1, 1'b1, 8'd3, 8'd3);
      drive_side(1'b1, 1'b1, 4'd1, 1'b1, 8'd7, 8'd2);
      got = 0; cyc = 0; bad = 1'b0;
      while (got < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if ((bus.op_ready_0 && !bus.gnt_0) || (bus.op_ready_1 && !bus.gnt_1) ||
             (bus.gnt_0 && bus.gnt_1)) bad = 1'b1;
         if (bus.res_valid) begin
            check($sformatf("tie%0d owner", got), bus.res_owner, got % 2);
            check($sformatf("tie%0d res", got), bus.res, (got % 2) ? 14 : 9);
            got++;
         end
      end
      check("tie jobs", got, 4);
      check("tie exclusive", bad, 0);
      idle_inputs();

      // Reset mid-FEED: res still holds 14 from the tie run.
      @(negedge clk);
      @(negedge clk);
      drive_side(1'b0, 1'b1, 4'd5, 1'b0, 8'd0, 8'd0);
      @(negedge clk);
      check("midrst granted", bus.gnt_0, 1);
      drive_side(1'b0, 1'b0, 4'd5, 1'b1, 8'd9, 8'd9);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst gnt_0", bus.gnt_0, 0);
      check("midrst op_ready_0", bus.op_ready_0, 0);
      check("midrst res", bus.res, 0);
      check("midrst res_owner", bus.res_owner, 0);
      check("midrst res_valid", bus.res_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.res_valid || bus.gnt_0 || bus.gnt_1) bad = 1'b1;
      end
      check("midrst quiet", bad, 0);
      v = '{who: 1'b0, len: 4'd1, a: {24'd0, 8'd5}, b: {24'd0, 8'd6},
            vmask: 16'hFFFF, exp_res: 16'd30, exp_rdy: 5'd1};
      run_vec(5, v);

      // Randomized two-client run against a job-level model.
      do_reset();
      pend[0] = 0; pend[1] = 0; idx[0] = 0; idx[1] = 0;
      jlen[0] = 0; jlen[1] = 0;
      busy = 0; last_m = 1; stray = 0; jobs = 0; busy_cyc = 0;
      exp_own = 0; exp_res = '0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         done_seen = 0;
         for (int s = 0; s < 2; s++) begin
            if ((rdy(s[0]) || gnt(s[0])) && !(busy && exp_own == s[0]))
               stray = 1;
         end
         if (bus.res_valid) begin
            done_seen = 1;
            if (!busy) begin
               check("rnd unexpected res_valid", 1, 0);
            end else begin
               check($sformatf("rnd%0d owner", jobs), bus.res_owner, exp_own);
               check($sformatf("rnd%0d res", jobs), bus.res, exp_res);
               pend[exp_own] = 0;
               busy = 0;
               jobs++;
            end
         end
         if (busy) begin
            busy_cyc++;
            if (busy_cyc > 400) begin
               check("rnd timeout", 0, 1);
               break;
            end
         end
         if (c < 5000) begin
            for (int s = 0; s < 2; s++)
               if (!pend[s] && $urandom_range(0, 3) == 0) new_job(s);
         end
         for (int s = 0; s < 2; s++) begin
            vbr = pend[s] && (idx[s] < jlen[s]) && ($urandom_range(0, 3) != 0);
            drive_side(s[0], pend[s], 4'(jlen[s]), vbr,
                       ja[s][idx[s] % 16], jb[s][idx[s] % 16]);
            if (vbr && rdy(s[0])) idx[s]++;
         end
         if (!busy && !done_seen && (pend[0] || pend[1])) begin
            exp_own  = (pend[0] && pend[1]) ? !last_m : pend[1];
            last_m   = exp_own;
            exp_res  = job_sum(exp_own);
            busy     = 1;
            busy_cyc = 0;
         end
      end
      check("rnd drained", {29'd0, busy, pend[0], pend[1]}, 0);
      check("rnd stray ready/gnt", stray, 0);
      check("rnd enough jobs", jobs > 50, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mac_job_scheduler.md
Name: mac_job_scheduler

Overview:
- Shares one registered-multiply / accumulate datapath (8x8 multiply, 16-bit accumulator, multiply register ahead of accumulator) between two requesters.
- Each requester submits a dot-product job of len_i operand pairs.
- The block arbitrates round-robin, gates the winner's operand stream into the pipeline, drains it, and returns one result tagged with the owner.
- Sits between DSP-side clients and the MAC resource.

Parameters:
- WIDTH, 8, operand width.
- ACC_WIDTH, 16, product register and accumulator width; results wrap modulo 2^ACC_WIDTH.
- LEN_WIDTH, 4, job-length field width (0..15 terms).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_0, req_1  in  1 each  job request (level); sampled only in IDLE.
- len_0, len_1  in  LEN_WIDTH each  term count, sampled on grant.
- a_0, b_0, a_1, b_1  in  WIDTH each  operand pair.
- op_valid_0, op_valid_1  in  1 each  operand pair valid.
- op_ready_0, op_ready_1  out  1 each  operand pair accepted this cycle if op_valid also high.
- gnt_0, gnt_1  out  1 each  requester owns datapath (FEED through DONE).
- res  out  ACC_WIDTH  result of last completed job; holds between jobs.
- res_valid  out  1  one-cycle pulse, res valid.
- res_owner  out  1  requester index of res.

Behaviour:
- Reset (reset=0, async): state=IDLE; mult, accum, res=0; pipeline valid bit=0; count=0; last_owner=1 (requester 0 wins first tie). All outputs 0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - If any req is high, grant one: the only requester, or on a tie the one != last_owner.
  - On that edge: owner<=winner, last_owner<=winner, count<=len_owner, accum<=0.
  - Next state is FEED if len>0, else DONE (res=0).
  - No req: stay in IDLE.
- FEED:
  - op_ready_owner=1; the other op_ready=0.
  - Accept = op_valid_owner & op_ready_owner.
  - On accept: mult<=a*b (full 2*WIDTH product, zero-extended/truncated to ACC_WIDTH), pipe_v<=1, count<=count-1.
  - No accept: pipe_v<=0; stall indefinitely, no timeout.
  - When the accepted pair has count==1, go to DRAIN.
- Accumulate stage, every state: if pipe_v, accum<=accum+mult (wraps, no saturation, no overflow flag).
- DRAIN: one cycle (last product enters accum); go to DONE.
- DONE:
  - res_valid=1, res=accum (final sum), res_owner=owner. res is registered on entry so it is valid throughout DONE.
  - Next edge: IDLE.
- Latency: if the last operand is accepted at edge E, res_valid is high in the cycle after edge E+1.
- Job cost: 1 grant cycle + len feed cycles (no bubbles) + 1 DRAIN + 1 DONE.
- gnt_owner high in FEED, DRAIN and DONE.
- req changes outside IDLE are ignored; a granted job always runs to completion.
- A requester still holding req in DONE is eligible again in the following IDLE, subject to round-robin.
- The non-owner's operands are never consumed.
- Reset mid-job: abort immediately; no res_valid. The next job starts from accum=0 with last_owner=1.
- Simultaneous reset release and req: req is sampled on the first clean edge after release.

Test Plan:
- Single job: after reset, req_0=1, len_0=3, pairs (2,3),(4,5),(10,10) streamed without gaps -> op_ready_0 high 3 cycles; res=126, res_owner=0, res_valid single pulse 2 edges after the last accept; gnt_1 stays 0.
- Tie arbitration: req_0 and req_1 held from reset, each len=1, pairs (3,3) and (7,2) -> jobs served 0,1,0,1; results 9 (owner 0) and 14 (owner 1) alternating; the losing side's op_ready stays 0.
- Wrap-around: len=2, pairs (255,255),(255,255) -> res=64514 (130050 mod 65536).
- Bubbles: len=4, op_valid toggling 1,0,0,1,1,0,1 with pairs (1,1),(2,2),(3,3),(4,4) -> res=30; stalls neither drop nor duplicate terms.
- Zero length: req_1=1, len_1=0 -> IDLE->DONE; res=0, res_owner=1, res_valid pulse in the cycle after the grant edge; op_ready_1 never asserted.
- Reset mid-FEED: job len=5 with 2 pairs accepted, then reset=0 for 1 cycle -> all outputs 0 immediately, no res_valid. Next job len=1 with (5,6) -> res=30 (no stale accumulation).
